lib_pow2_seq: RTL and testbench
===============================

LIB_POW2_SEQ -- requirements
Module: lib_pow2_seq

Interface
REQ-001 SHALL have parameter LSB_MSB, default 0, meaning search order: 0 = lowest set bit first, 1 = highest set bit first.
REQ-002 SHALL have parameter WIDTH, default 16, meaning input vector width; WIDTH >= 2.
REQ-003 SHALL have parameter MAX_BITS, default WIDTH, meaning maximum one-hot beats emitted per accepted vector; 1 <= MAX_BITS <= WIDTH.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 in_vld  input  1  input vector valid.
REQ-008 in_rdy  output  1  block accepts in_vect this cycle.
REQ-009 in_vect  input  WIDTH  vector to decompose.
REQ-010 out_vld  output  1  one-hot beat valid.
REQ-011 out_rdy  input  1  downstream accepts beat.
REQ-012 out_onehot  output  WIDTH  current one-hot (all-zero for an empty vector).
REQ-013 out_idx  output  $clog2(WIDTH)  bit position of out_onehot; 0 when out_onehot is zero.
REQ-014 out_cnt  output  $clog2(MAX_BITS+1)  beat number within the current vector, starting at 0.
REQ-015 out_last  output  1  final beat of the current vector.
REQ-016 out_trunc  output  1  set bits remain unemitted because MAX_BITS was reached; meaningful only with out_last.

Function
REQ-017 SHALL implement two states: IDLE and RUN.
REQ-018 Input handshake = in_vld & in_rdy; output handshake = out_vld & out_rdy.
REQ-019 in_rdy SHALL be 1 in IDLE, and 1 in RUN only when an output handshake with out_last=1 occurs in the same cycle; 0 otherwise.
REQ-020 On an input handshake, SHALL load in_vect into a residual register, clear the beat counter, and be in RUN in the next cycle.
REQ-021 First beat latency SHALL be exactly 1 cycle: handshake in cycle N -> out_vld=1 in cycle N+1.
REQ-022 In RUN, out_vld SHALL be 1; out_onehot = first set bit of the residual in LSB_MSB order, driven combinationally from registered state.
REQ-023 out_last SHALL be 1 when residual XOR out_onehot is zero, or when out_cnt = MAX_BITS-1.
REQ-024 out_trunc SHALL be 1 when out_last=1 and residual XOR out_onehot is nonzero; 0 otherwise.
REQ-025 On a non-last output handshake, SHALL clear the emitted bit in the residual and increment the counter by 1.
REQ-026 On a last output handshake without an input handshake, SHALL return to IDLE; with one, SHALL load the new vector and stay in RUN (back-to-back, no bubble).
REQ-027 Zero vector SHALL produce exactly one beat: out_onehot=0, out_idx=0, out_cnt=0, out_last=1, out_trunc=0.
REQ-028 While out_vld=1 and out_rdy=0, all out_* signals SHALL hold stable.
REQ-029 in_vect SHALL be ignored when no input handshake occurs.
REQ-030 In IDLE, out_vld, out_onehot, out_idx, out_cnt, out_last and out_trunc SHALL be 0.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, residual 0 and counter 0, and SHALL drive every out_* signal to 0 and in_rdy to 1, regardless of clk.
REQ-032 Reset during RUN SHALL discard the in-flight vector; no beats of that vector SHALL appear after rst is deasserted.

Verification (WIDTH=8 unless stated)
REQ-033 LSB_MSB=0, out_rdy=1, in_vect=8'b1010_0100 -> cycles N+1..N+3 emit onehot 04/20/80, idx 2/5/7, cnt 0/1/2, last only on 80, trunc=0.
REQ-034 LSB_MSB=1, same vector -> onehot 80/20/04, idx 7/5/2, last on 04.
REQ-035 in_vect=8'h00 -> single beat: onehot 00, last=1, trunc=0; then IDLE.
REQ-036 MAX_BITS=2, in_vect=8'hFF -> beats 01, 02; second beat has last=1 and trunc=1; then IDLE.
REQ-037 Hold out_rdy=0 for 3 cycles on beat 20 of REQ-033 -> outputs frozen; present vector 8'h81 so that it is accepted on the last handshake -> beat 01 in the next cycle, no gap.
REQ-038 Assert rst mid-RUN after beat 04 -> out_vld=0 at once, in_rdy=1; after release, the next vector 8'h10 yields a single beat 10 with cnt=0 and last=1.

Source files
------------

// File: rtl/lib_pow2_seq.sv
// Power-of-two decomposer: splits a vector into one-hot beats.
// Beats follow the set bits in LSB- or MSB-first order, capped at MAX_BITS.
module lib_pow2_seq #(
  parameter int LSB_MSB  = 0,
  parameter int WIDTH    = 16,
  parameter int MAX_BITS = WIDTH,
  localparam int IW = $clog2(WIDTH),
  localparam int CW = $clog2(MAX_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_vect,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IW-1:0]    out_idx,
  output logic [CW-1:0]    out_cnt,
  output logic             out_last,
  output logic             out_trunc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;

  logic             run;
  logic [WIDTH-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic [WIDTH-1:0] rem;
  logic             cap;
  logic             out_hs;
  logic             in_hs;

  assign run = (state == RUN);

  // Priority pick: scan from the far end so the preferred bit wins last.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      j = (LSB_MSB != 0) ? i : (WIDTH - 1 - i);
      if (res[j]) begin
        pick     = '0;
        pick[j]  = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  assign rem = res ^ pick;
  assign cap = (cnt == CW'(MAX_BITS - 1));

  // Beat outputs come straight from registered state; IDLE forces zeros.
  always_comb begin
    out_vld    = run;
    out_onehot = run ? pick : '0;
    out_idx    = run ? pick_idx : '0;
    out_cnt    = run ? cnt : '0;
    out_last   = run & ((rem == '0) | cap);
    out_trunc  = run & ((rem == '0) | cap) & (rem != '0);
  end

  assign out_hs = out_vld & out_rdy;
  assign in_rdy = ~run | (out_hs & out_last);
  assign in_hs  = in_vld & in_rdy;

  // Sequencer: load on accept, peel one bit per beat, leave on last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      res   <= '0;
      cnt   <= '0;
    end else if (in_hs) begin
      state <= RUN;
      res   <= in_vect;
      cnt   <= '0;
    end else if (out_hs) begin
      if (out_last) begin
        state <= IDLE;
        res   <= '0;
        cnt   <= '0;
      end else begin
        res <= rem;
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lib_pow2_seq.sv
// Directed bench for lib_pow2_seq: LSB/MSB order, zero vector,
// truncation, backpressure with back-to-back load, and mid-run reset.
module tb_lib_pow2_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // d0: LSB first, MAX_BITS=8
  logic       a_iv, a_ir, a_ov, a_or, a_l, a_t;
  logic [7:0] a_vec, a_oh;
  logic [2:0] a_idx;
  logic [3:0] a_cnt;

  // d1: MSB first, MAX_BITS=8
  logic       b_iv, b_ir, b_ov, b_or, b_l, b_t;
  logic [7:0] b_vec, b_oh;
  logic [2:0] b_idx;
  logic [3:0] b_cnt;

  // d2: LSB first, MAX_BITS=2
  logic       c_iv, c_ir, c_ov, c_or, c_l, c_t;
  logic [7:0] c_vec, c_oh;
  logic [2:0] c_idx;
  logic [1:0] c_cnt;

  lib_pow2_seq #(.LSB_MSB(0), .WIDTH(8), .MAX_BITS(8)) d0 (
    .clk(clk), .rst(rst),
    .in_vld(a_iv), .in_rdy(a_ir), .in_vect(a_vec),
    .out_vld(a_ov), .out_rdy(a_or), .out_onehot(a_oh),
    .out_idx(a_idx), .out_cnt(a_cnt),
    .out_last(a_l), .out_trunc(a_t)
  );

  lib_pow2_seq #(.LSB_MSB(1), .WIDTH(8), .MAX_BITS(8)) d1 (
    .clk(clk), .rst(rst),
    .in_vld(b_iv), .in_rdy(b_ir), .in_vect(b_vec),
    .out_vld(b_ov), .out_rdy(b_or), .out_onehot(b_oh),
    .out_idx(b_idx), .out_cnt(b_cnt),
    .out_last(b_l), .out_trunc(b_t)
  );

  lib_pow2_seq #(.LSB_MSB(0), .WIDTH(8), .MAX_BITS(2)) d2 (
    .clk(clk), .rst(rst),
    .in_vld(c_iv), .in_rdy(c_ir), .in_vect(c_vec),
    .out_vld(c_ov), .out_rdy(c_or), .out_onehot(c_oh),
    .out_idx(c_idx), .out_cnt(c_cnt),
    .out_last(c_l), .out_trunc(c_t)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input string tag, input logic v,
                        input logic [7:0] oh, input logic [2:0] ix,
                        input logic [3:0] cn, input logic l,
                        input logic t);
    chk({tag, ".vld"}, 32'(a_ov), 32'(v));
    chk({tag, ".oh"}, 32'(a_oh), 32'(oh));
    chk({tag, ".idx"}, 32'(a_idx), 32'(ix));
    chk({tag, ".cnt"}, 32'(a_cnt), 32'(cn));
    chk({tag, ".last"}, 32'(a_l), 32'(l));
    chk({tag, ".trunc"}, 32'(a_t), 32'(t));
  endtask

  task automatic beat_b(input string tag, input logic v,
                        input logic [7:0] oh, input logic [2:0] ix,
                        input logic [3:0] cn, input logic l,
                        input logic t);
    chk({tag, ".vld"}, 32'(b_ov), 32'(v));
    chk({tag, ".oh"}, 32'(b_oh), 32'(oh));
    chk({tag, ".idx"}, 32'(b_idx), 32'(ix));
    chk({tag, ".cnt"}, 32'(b_cnt), 32'(cn));
    chk({tag, ".last"}, 32'(b_l), 32'(l));
    chk({tag, ".trunc"}, 32'(b_t), 32'(t));
  endtask

  task automatic beat_c(input string tag, input logic v,
                        input logic [7:0] oh, input logic [2:0] ix,
                        input logic [1:0] cn, input logic l,
                        input logic t);
    chk({tag, ".vld"}, 32'(c_ov), 32'(v));
    chk({tag, ".oh"}, 32'(c_oh), 32'(oh));
    chk({tag, ".idx"}, 32'(c_idx), 32'(ix));
    chk({tag, ".cnt"}, 32'(c_cnt), 32'(cn));
    chk({tag, ".last"}, 32'(c_l), 32'(l));
    chk({tag, ".trunc"}, 32'(c_t), 32'(t));
  endtask

  initial begin
    a_iv = 0; a_vec = '0; a_or = 1;
    b_iv = 0; b_vec = '0; b_or = 1;
    c_iv = 0; c_vec = '0; c_or = 1;

    // reset state
    #2;
    beat_a("rst_a", 0, 8'h00, 0, 0, 0, 0);
    chk("rst_a.in_rdy", 32'(a_ir), 32'd1);
    chk("rst_b.vld", 32'(b_ov), 32'd0);
    chk("rst_c.in_rdy", 32'(c_ir), 32'd1);
    cyc();
    cyc();
    rst = 0;
    cyc();

    // LSB-first decomposition of A4
    a_iv = 1; a_vec = 8'hA4;
    chk("lsb.in_rdy", 32'(a_ir), 32'd1);
    cyc();
    a_iv = 0; a_vec = 8'h5A;
    beat_a("lsb0", 1, 8'h04, 2, 0, 0, 0);
    chk("lsb0.in_rdy", 32'(a_ir), 32'd0);
    cyc();
    beat_a("lsb1", 1, 8'h20, 5, 1, 0, 0);
    cyc();
    beat_a("lsb2", 1, 8'h80, 7, 2, 1, 0);
    chk("lsb2.in_rdy", 32'(a_ir), 32'd1);
    cyc();
    beat_a("lsb_idle", 0, 8'h00, 0, 0, 0, 0);

    // MSB-first decomposition of A4
    b_iv = 1; b_vec = 8'hA4;
    cyc();
    b_iv = 0;
    beat_b("msb0", 1, 8'h80, 7, 0, 0, 0);
    cyc();
    beat_b("msb1", 1, 8'h20, 5, 1, 0, 0);
    cyc();
    beat_b("msb2", 1, 8'h04, 2, 2, 1, 0);
    cyc();
    beat_b("msb_idle", 0, 8'h00, 0, 0, 0, 0);

    // zero vector gives one empty last beat
    a_iv = 1; a_vec = 8'h00;
    cyc();
    a_iv = 0;
    beat_a("zero", 1, 8'h00, 0, 0, 1, 0);
    cyc();
    beat_a("zero_idle", 0, 8'h00, 0, 0, 0, 0);

    // truncation at MAX_BITS=2
    c_iv = 1; c_vec = 8'hFF;
    cyc();
    c_iv = 0;
    beat_c("tr0", 1, 8'h01, 0, 0, 0, 0);
    cyc();
    beat_c("tr1", 1, 8'h02, 1, 1, 1, 1);
    cyc();
    beat_c("tr_idle", 0, 8'h00, 0, 0, 0, 0);

    // backpressure on beat 20, then back-to-back load of 81
    a_iv = 1; a_vec = 8'hA4;
    cyc();
    a_iv = 0;
    beat_a("bp0", 1, 8'h04, 2, 0, 0, 0);
    cyc();
    a_or = 0;
    beat_a("bp1", 1, 8'h20, 5, 1, 0, 0);
    a_iv = 1; a_vec = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      cyc();
      beat_a($sformatf("stall%0d", k), 1, 8'h20, 5, 1, 0, 0);
      chk($sformatf("stall%0d.in_rdy", k), 32'(a_ir), 32'd0);
    end
    a_iv = 0;
    a_or = 1;
    cyc();
    beat_a("bp2", 1, 8'h80, 7, 2, 1, 0);
    a_iv = 1; a_vec = 8'h81;
    chk("b2b.in_rdy", 32'(a_ir), 32'd1);
    cyc();
    a_iv = 0; a_vec = 8'h00;
    beat_a("b2b0", 1, 8'h01, 0, 0, 0, 0);
    cyc();
    beat_a("b2b1", 1, 8'h80, 7, 1, 1, 0);
    cyc();
    beat_a("b2b_idle", 0, 8'h00, 0, 0, 0, 0);

    // reset mid-run discards the vector
    a_iv = 1; a_vec = 8'hA4;
    cyc();
    a_iv = 0;
    beat_a("mr0", 1, 8'h04, 2, 0, 0, 0);
    cyc();
    rst = 1;
    #1;
    beat_a("mr_rst", 0, 8'h00, 0, 0, 0, 0);
    chk("mr_rst.in_rdy", 32'(a_ir), 32'd1);
    cyc();
    rst = 0;
    cyc();
    beat_a("mr_after", 0, 8'h00, 0, 0, 0, 0);
    a_iv = 1; a_vec = 8'h10;
    cyc();
    a_iv = 0;
    beat_a("mr_new", 1, 8'h10, 4, 0, 1, 0);
    cyc();
    beat_a("mr_idle", 0, 8'h00, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
